// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage buffer: FSM state encoding, slot
// control bundle, and the IF/ID NOP encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic load;
        logic clear;
    } slot_ctl_t;

    localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/pipe_slot.sv
// One DATA_W storage slot. Clear takes priority over load, and reset forces
// the slot to CLR_V.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W = 64,
    parameter logic [DATA_W-1:0]  CLR_V  = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  slot_ctl_t         ctl,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] value
);

    always_ff @(posedge clk_i) begin
        if (!rst_i || ctl.clear)
            value <= CLR_V;
        else if (ctl.load)
            value <= din;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with a 2-entry skid buffer, flush and
// bubble output. Optional perf counters are enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] BUBBLE_V = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    pipe_state_t       state, nxt_state;
    slot_ctl_t         main_ctl, skid_ctl;
    logic [DATA_W-1:0] main_din, main_q, skid_q;
    logic              acc, pop;

    assign acc = in_valid_i & in_ready_o;
    assign pop = out_valid_o & out_ready_i;

    always_comb begin
        nxt_state = state;
        main_ctl  = '0;
        skid_ctl  = '0;
        main_din  = in_data_i;
        if (flush_i) begin
            // wrong-path entries die; any concurrent acc is dropped too
            nxt_state      = EMPTY;
            main_ctl.clear = 1'b1;
            skid_ctl.clear = 1'b1;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    nxt_state     = HALF;
                    main_ctl.load = 1'b1;
                end
                HALF: begin
                    if (acc && !pop) begin
                        nxt_state     = FULL;
                        skid_ctl.load = 1'b1;
                    end else if (acc && pop) begin
                        main_ctl.load = 1'b1;
                    end else if (pop) begin
                        nxt_state      = EMPTY;
                        main_ctl.clear = 1'b1;
                    end
                end
                FULL: if (pop) begin
                    nxt_state      = HALF;
                    main_ctl.load  = 1'b1;
                    main_din       = skid_q;
                    skid_ctl.clear = 1'b1;
                end
                default: nxt_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            occ_o       <= 2'd0;
        end else begin
            state       <= nxt_state;
            out_valid_o <= (nxt_state != EMPTY);
            in_ready_o  <= (nxt_state != FULL);
            occ_o       <= nxt_state;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CLR_V(BUBBLE_V)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ctl   (main_ctl),
        .din   (main_din),
        .value (main_q)
    );

    pipe_slot #(.DATA_W(DATA_W), .CLR_V(BUBBLE_V)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ctl   (skid_ctl),
        .din   (in_data_i),
        .value (skid_q)
    );

    // main is cleared whenever the stage empties, so it already reads BUBBLE_V
    assign out_data_o = main_q;

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (out_valid_o && !out_ready_i)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_i && occ_o != 2'd0)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, perf-counter sequence
// (when PIPE_STAGE_PERF_EN is defined) and random traffic vs a queue model.
module tb_pipe_stage_buf;
    localparam int            W   = 64;
    localparam logic [W-1:0]  BUB = 64'hBBBB_0000_0000_0013;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    int unsigned  m_stall = 0;
    int unsigned  m_flush = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(W), .BUBBLE_V(BUB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occ_o       (occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    typedef struct {
        logic         r, f, v;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic [W-1:0] ed;
        logic [1:0]   eo;
        logic         er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic v, logic [W-1:0] d, logic ordy,
                                logic ev, logic [W-1:0] ed, logic [1:0] eo, logic er);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.d = d; x.ordy = ordy;
        x.ev = ev; x.ed = ed; x.eo = eo; x.er = er;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle and advance the queue model from the pre-edge state.
    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [W-1:0] d, input logic ordy);
        int sz;
        bit acc_m, pop_m;
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
        sz    = mq.size();
        acc_m = v && (sz < 2);
        pop_m = (sz > 0) && ordy;
        @(posedge clk);
        #1;
        if (!r) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (sz > 0 && !ordy) m_stall++;
            if (f && sz > 0)     m_flush++;
            if (f) mq.delete();
            else begin
                if (pop_m) void'(mq.pop_front());
                if (acc_m) mq.push_back(d);
            end
        end
    endtask

    task automatic chk_model(input int n);
        int sz;
        sz = mq.size();
        chk($sformatf("rnd%0d.valid", n), 64'(out_valid), 64'(sz > 0));
        chk($sformatf("rnd%0d.data", n), out_data, (sz > 0) ? mq[0] : BUB);
        chk($sformatf("rnd%0d.occ", n), 64'(occ), 64'(sz));
        chk($sformatf("rnd%0d.ready", n), 64'(in_ready), 64'(sz < 2));
`ifdef PIPE_STAGE_PERF_EN
        chk($sformatf("rnd%0d.stall_cnt", n), 64'(stall_cnt), 64'(m_stall));
        chk($sformatf("rnd%0d.flush_cnt", n), 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset held 2 cycles with in_valid high
        tbl.push_back(mk(0,0,1,64'h99,0, 0,BUB,0,1));
        tbl.push_back(mk(0,0,1,64'h99,0, 0,BUB,0,1));
        // streaming 0x11..0x18, then drain
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,0,1,64'h11+64'(i),1, 1,64'h11+64'(i),1,1));
        tbl.push_back(mk(1,0,0,64'h0,1, 0,BUB,0,1));
        // stall A,B,C; data change while not ready; release
        tbl.push_back(mk(1,0,1,64'hA,0, 1,64'hA,1,1));
        tbl.push_back(mk(1,0,1,64'hB,0, 1,64'hA,2,0));
        tbl.push_back(mk(1,0,1,64'hEE,0, 1,64'hA,2,0));
        tbl.push_back(mk(1,0,1,64'hC,0, 1,64'hA,2,0));
        tbl.push_back(mk(1,0,1,64'hC,1, 1,64'hB,1,1));
        tbl.push_back(mk(1,0,1,64'hC,1, 1,64'hC,1,1));
        tbl.push_back(mk(1,0,0,64'h0,1, 0,BUB,0,1));
        // flush with simultaneous acc
        tbl.push_back(mk(1,0,1,64'h5,0, 1,64'h5,1,1));
        tbl.push_back(mk(1,1,1,64'h6,0, 0,BUB,0,1));
        tbl.push_back(mk(1,0,0,64'h0,1, 0,BUB,0,1));
        // pop plus flush in FULL
        tbl.push_back(mk(1,0,1,64'h21,0, 1,64'h21,1,1));
        tbl.push_back(mk(1,0,1,64'h22,0, 1,64'h21,2,0));
        tbl.push_back(mk(1,1,1,64'h23,1, 0,BUB,0,1));
        tbl.push_back(mk(1,0,0,64'h0,1, 0,BUB,0,1));
        // reset mid-operation beats flush and handshakes
        tbl.push_back(mk(1,0,1,64'h31,0, 1,64'h31,1,1));
        tbl.push_back(mk(1,0,1,64'h32,0, 1,64'h31,2,0));
        tbl.push_back(mk(0,1,1,64'h33,1, 0,BUB,0,1));
        tbl.push_back(mk(1,0,1,64'h34,1, 1,64'h34,1,1));
        tbl.push_back(mk(1,0,0,64'h0,1, 0,BUB,0,1));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d.data", i), out_data, tbl[i].ed);
            chk($sformatf("vec%0d.occ", i), 64'(occ), 64'(tbl[i].eo));
            chk($sformatf("vec%0d.ready", i), 64'(in_ready), 64'(tbl[i].er));
        end

`ifdef PIPE_STAGE_PERF_EN
        cycle(0,0,0,64'h0,0);
        chk("perf.reset_stall", 64'(stall_cnt), 64'd0);
        chk("perf.reset_flush", 64'(flush_cnt), 64'd0);
        cycle(1,0,1,64'h41,0);
        for (int i = 0; i < 3; i++) cycle(1,0,0,64'h0,0);
        chk("perf.stall3", 64'(stall_cnt), 64'd3);
        cycle(1,1,0,64'h0,1);
        chk("perf.flush1", 64'(flush_cnt), 64'd1);
        chk("perf.stall_after_flush", 64'(stall_cnt), 64'd3);
        cycle(1,1,0,64'h0,0);
        chk("perf.flush_empty", 64'(flush_cnt), 64'd1);
        chk("perf.stall_empty", 64'(stall_cnt), 64'd3);
`endif

        // random traffic against the queue model
        cycle(0,0,0,64'h0,0);
        chk_model(-1);
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0,49) != 0,
                  $urandom_range(0,9) == 0,
                  $urandom_range(0,9) < 7,
                  {$urandom(), $urandom()},
                  $urandom_range(0,9) < 6);
            chk_model(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
